mod_boot_runner: RTL and testbench
==================================

// Module: mod_boot_runner
// PURPOSE
//  Synthesizable program-load/run harness: receives a program image over a byte stream,
//  writes it into the CPU instruction ROM, releases CPU reset, runs until halt or timeout,
//  then reads one data-RAM word and reports it as the result.
//  Sits between a host byte link and mod_cpu's ROM write port, reset input and RAM read port.
// PARAMETERS
//  ADDR_W      8    ROM/RAM address width; ROM depth = 2**ADDR_W words
//  WORD_W      16   ROM/RAM word width; must be a multiple of 8
//  RUN_CYCLES  500  max CPU cycles after reset release before timeout
//  RESULT_ADDR 0    RAM address read as result
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  rx_data      in   8       host byte
//  rx_valid     in   1       rx_data valid
//  rx_ready     out  1       byte accepted when rx_valid & rx_ready
//  rom_we       out  1       ROM write strobe, one cycle per word
//  rom_addr     out  ADDR_W  ROM write address
//  rom_wdata    out  WORD_W  ROM write data
//  cpu_reset    out  1       CPU reset, high except in RUN
//  cpu_halt     in   1       CPU halted (level)
//  ram_addr     out  ADDR_W  RAM read address (RAM has 1-cycle registered read)
//  ram_rdata    in   WORD_W  RAM read data
//  result       out  WORD_W  captured RAM[RESULT_ADDR]
//  result_valid out  1       result holds a valid value
//  timeout      out  1       run ended by RUN_CYCLES, not halt
//  overflow     out  1       image longer than ROM depth
// BEHAVIOUR
//  Reset: state IDLE; cpu_reset=1; rx_ready=0; rom_we=0; rom_addr=0; rom_wdata=0; ram_addr=0;
//   result=0; result_valid=0; timeout=0; overflow=0. Reset in any state aborts to IDLE.
//  States: IDLE -> HDR -> LOAD -> PAD -> RUN -> READ -> DONE.
//  IDLE: one cycle after reset, then HDR; rx_ready=1.
//  HDR: accept 2 bytes: N = {byte1, byte0} (word count, little-endian); then LOAD.
//  LOAD: rx_ready=1; word assembled MSB byte first from WORD_W/8 bytes; rom_we pulses the
//   cycle after the last byte with rom_addr=k (k=0..N-1).
//  Words with k >= 2**ADDR_W are consumed, not written; overflow=1 (sticky until next HDR).
//  N=0: LOAD is skipped.
//  PAD: see CONFIGURATION; rx_ready=0.
//  RUN: cpu_reset=0. A counter starts at 0 and increments each RUN cycle.
//   cpu_halt=1 -> READ with timeout=0.
//   counter==RUN_CYCLES-1 without halt -> READ with timeout=1.
//   Simultaneous halt and last count -> halt wins, timeout=0.
//  READ: cpu_reset=1; ram_addr=RESULT_ADDR; ram_rdata captured into result 1 cycle later;
//   result_valid=1 on entry to DONE.
//  DONE: result, result_valid and timeout held; rx_ready=1.
//   An accepted byte is header byte0 of a new image: clears result_valid, timeout and overflow;
//   state -> HDR (expecting byte1).
//  rx_ready=0 in PAD, RUN and READ; bytes offered there are not consumed.
//  Counter width: $clog2(RUN_CYCLES+1). Address counter ADDR_W+1 bits so overflow is detectable.
// CONFIGURATION
//  BOOT_RUNNER_PAD_EN defined:
//   PAD writes 0 to ROM addresses N..2**ADDR_W-1, one per cycle (rom_we=1), then RUN.
//   With overflow or N=2**ADDR_W, PAD lasts 0 cycles.
//  BOOT_RUNNER_PAD_EN undefined:
//   PAD lasts 0 cycles; ROM locations above N keep prior contents.
// STRUCTURE
//  boot_defs.vh: state encodings (localparams), header byte count 2, BYTES_PER_WORD = WORD_W/8.
//  Sub-module mod_word_assembler:
//   bytes in with valid/ready; emits a WORD_W word plus a 1-cycle word_valid; MSB first;
//   synchronous clear.
//  The top level owns the FSM, address/run counters and the result register.
// TESTING
//  1) Header 03 00, words 1234 5678 9ABC; PAD off:
//     -> three rom_we pulses at addr 0,1,2 with matching data; cpu_reset falls after the last write.
//  2) Same image with PAD_EN, ADDR_W=4:
//     -> 13 extra writes of 0000 at addr 3..15, then RUN.
//  3) cpu_halt rises on run cycle 10, RAM[0]=002A:
//     -> result=002A, result_valid=1, timeout=0, cpu_reset=1.
//  4) cpu_halt never rises, RUN_CYCLES=20:
//     -> exactly 20 cycles with cpu_reset=0; timeout=1, result_valid=1.
//  5) ADDR_W=2, N=6:
//     -> writes at addr 0..3 only; all 12 bytes consumed; overflow=1.
//  6) reset pulsed mid-LOAD, then a new 1-word image:
//     -> IDLE outputs; the new load starts at addr 0; the old partial word is discarded.

Source files
------------

// File: rtl/mod_boot_runner_pkg.sv
// Shared definitions for the boot runner: FSM state encoding and header layout.
package mod_boot_runner_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_PAD  = 3'd3,
        S_RUN  = 3'd4,
        S_READ = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam int HDR_BYTES = 2;

    function automatic int bytes_per_word(input int word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/mod_word_assembler.sv
// Packs a byte stream into WORD_W words, most significant byte first.
// word_valid_o pulses in the same cycle the final byte of a word is taken.
module mod_word_assembler
    import mod_boot_runner_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);
    localparam int BPW = bytes_per_word(WORD_W);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt_q;
    logic          take;

    assign byte_ready_o = ~clr_i;
    assign take         = byte_valid_i & byte_ready_o;
    assign word_valid_o = take && (cnt_q == CW'(BPW - 1));

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (take) begin
            cnt_q <= word_valid_o ? '0 : cnt_q + 1'b1;
        end
    end

    generate
        if (BPW > 1) begin : g_multi
            // Earlier bytes of the current word; stale contents are fully shifted out.
            logic [WORD_W-9:0] acc_q;
            always_ff @(posedge clk) begin
                if (take) acc_q <= word_o[WORD_W-9:0];
            end
            assign word_o = {acc_q, byte_i};
        end else begin : g_single
            assign word_o = byte_i;
        end
    endgenerate

endmodule

// File: rtl/mod_boot_runner.sv
// Program load/run harness: byte-stream image -> CPU ROM, run to halt or timeout, read result.
// Build option BOOT_RUNNER_PAD_EN zero-fills ROM above the image before the run.
module mod_boot_runner
    import mod_boot_runner_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WORD_W      = 16,
    parameter int RUN_CYCLES  = 500,
    parameter int RESULT_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halt,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic [WORD_W-1:0] result,
    output logic              result_valid,
    output logic              timeout,
    output logic              overflow
);
    localparam int RCW = $clog2(RUN_CYCLES + 1);

    state_t            state_q;
    logic              hdr_hi_q;
    logic [7:0]        n_lo_q;
    logic [15:0]       n_q;
    logic [15:0]       wcnt_q;
    logic [ADDR_W:0]   addr_q;
    logic [RCW-1:0]    run_q;
    logic              read_ph_q;
    logic              rx_ready_q, rom_we_q, cpu_reset_q;
    logic              result_valid_q, timeout_q, overflow_q;
    logic [ADDR_W-1:0] rom_addr_q, ram_addr_q;
    logic [WORD_W-1:0] rom_wdata_q, result_q;

    logic              accept;
    logic [15:0]       n_d;
    logic              asm_ready, asm_valid;
    logic [WORD_W-1:0] asm_word;

    assign accept = rx_valid & rx_ready_q;
    assign n_d    = {rx_data, n_lo_q};

    mod_word_assembler #(.WORD_W(WORD_W)) u_asm (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (state_q != S_LOAD),
        .byte_i       (rx_data),
        .byte_valid_i (accept && (state_q == S_LOAD)),
        .byte_ready_o (asm_ready),
        .word_o       (asm_word),
        .word_valid_o (asm_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            hdr_hi_q       <= 1'b0;
            n_lo_q         <= '0;
            n_q            <= '0;
            wcnt_q         <= '0;
            addr_q         <= '0;
            run_q          <= '0;
            read_ph_q      <= 1'b0;
            rx_ready_q     <= 1'b0;
            rom_we_q       <= 1'b0;
            rom_addr_q     <= '0;
            rom_wdata_q    <= '0;
            cpu_reset_q    <= 1'b1;
            ram_addr_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            rom_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_HDR;
                    rx_ready_q <= 1'b1;
                    hdr_hi_q   <= 1'b0;
                end
                S_HDR: begin
                    if (accept && !hdr_hi_q) begin
                        n_lo_q     <= rx_data;
                        hdr_hi_q   <= 1'b1;
                        overflow_q <= 1'b0;
                    end else if (accept) begin
                        hdr_hi_q <= 1'b0;
                        n_q      <= n_d;
                        wcnt_q   <= '0;
                        addr_q   <= '0;
                        if (n_d == 16'd0) begin
                            state_q    <= S_PAD;
                            rx_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (asm_valid && asm_ready) begin
                        // Words past the ROM end are swallowed; addr_q saturates at depth.
                        if (!addr_q[ADDR_W]) begin
                            rom_we_q    <= 1'b1;
                            rom_addr_q  <= addr_q[ADDR_W-1:0];
                            rom_wdata_q <= asm_word;
                            addr_q      <= addr_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        wcnt_q <= wcnt_q + 16'd1;
                        if (wcnt_q == n_q - 16'd1) begin
                            state_q    <= S_PAD;
                            rx_ready_q <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    // CPU reset is released only once the final ROM write has retired.
`ifdef BOOT_RUNNER_PAD_EN
                    if (!addr_q[ADDR_W]) begin
                        rom_we_q    <= 1'b1;
                        rom_addr_q  <= addr_q[ADDR_W-1:0];
                        rom_wdata_q <= '0;
                        addr_q      <= addr_q + 1'b1;
                    end else begin
                        state_q     <= S_RUN;
                        cpu_reset_q <= 1'b0;
                        run_q       <= '0;
                    end
`else
                    state_q     <= S_RUN;
                    cpu_reset_q <= 1'b0;
                    run_q       <= '0;
`endif
                end
                S_RUN: begin
                    if (cpu_halt || (run_q == RCW'(RUN_CYCLES - 1))) begin
                        state_q     <= S_READ;
                        timeout_q   <= ~cpu_halt;
                        cpu_reset_q <= 1'b1;
                        ram_addr_q  <= ADDR_W'(RESULT_ADDR);
                        read_ph_q   <= 1'b0;
                    end else begin
                        run_q <= run_q + 1'b1;
                    end
                end
                S_READ: begin
                    // First cycle presents the address; RAM data is valid in the second.
                    if (!read_ph_q) begin
                        read_ph_q <= 1'b1;
                    end else begin
                        result_q       <= ram_rdata;
                        result_valid_q <= 1'b1;
                        rx_ready_q     <= 1'b1;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        result_valid_q <= 1'b0;
                        timeout_q      <= 1'b0;
                        overflow_q     <= 1'b0;
                        n_lo_q         <= rx_data;
                        hdr_hi_q       <= 1'b1;
                        state_q        <= S_HDR;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_wdata    = rom_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign ram_addr     = ram_addr_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_mod_boot_runner.sv
// Self-checking bench for mod_boot_runner: table of images plus reset-state and mid-load reset sequences.
// Uses a 4-word ROM, 20-cycle run limit and result address 1.
module tb_mod_boot_runner;
    localparam int ADDR_W      = 2;
    localparam int WORD_W      = 16;
    localparam int RUN_CYCLES  = 20;
    localparam int RESULT_ADDR = 1;
    localparam int DEPTH       = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_wdata;
    logic              cpu_reset;
    logic              cpu_halt;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] result;
    logic              result_valid;
    logic              timeout;
    logic              overflow;

    always #5 clk = ~clk;

    mod_boot_runner #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .RUN_CYCLES(RUN_CYCLES), .RESULT_ADDR(RESULT_ADDR)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_reset(cpu_reset),
        .cpu_halt(cpu_halt), .ram_addr(ram_addr), .ram_rdata(ram_rdata), .result(result),
        .result_valid(result_valid), .timeout(timeout), .overflow(overflow)
    );

    // Data RAM with one-cycle registered read
    logic [WORD_W-1:0] ram [0:DEPTH-1];
    always @(posedge clk) ram_rdata <= ram[ram_addr];

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } wr_t;

    wr_t wr_log[$];
    int  low_cnt    = 0;
    int  wr_in_run  = 0;
    int  rdy_in_run = 0;

    always @(negedge clk) begin
        if (rom_we) begin
            wr_log.push_back('{rom_addr, rom_wdata});
            if (!cpu_reset) wr_in_run++;
        end
        if (!cpu_reset) begin
            low_cnt++;
            if (rx_ready) rdy_in_run++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            errors++;
            $display("FAIL rx_accept: byte %h not accepted within 200 cycles", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // halt_at = run cycle index (counter value) on which cpu_halt is seen high; -1 = never
    typedef struct {
        int                 n;
        logic [0:5][15:0]   w;
        int                 halt_at;
        logic [WORD_W-1:0]  ramv;
        int                 exp_low;
        logic               exp_to;
        logic               exp_ovf;
    } vec_t;

    task automatic wait_done(input int halt_at, input int lbase);
        int t;
        t = 0;
        while (!result_valid && t < 400) begin
            @(negedge clk);
            #1;
            if (halt_at >= 0 && (low_cnt - lbase) >= halt_at + 1) cpu_halt = 1'b1;
            t++;
        end
        if (t >= 400) begin
            errors++;
            $display("FAIL done_wait: result_valid not seen within 400 cycles");
        end
        cpu_halt = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int wbase, lbase, exp_cnt, nw;
        logic [15:0] nn;
        nn = 16'(v.n);
        ram[RESULT_ADDR] = v.ramv;
        wbase = wr_log.size();
        lbase = low_cnt;
        send_byte(nn[7:0]);
        if (i > 0) begin
            chk($sformatf("v%0d_hdr_clr_valid", i), 32'(result_valid), 32'd0);
            chk($sformatf("v%0d_hdr_clr_ovf", i), 32'(overflow), 32'd0);
            chk($sformatf("v%0d_hdr_clr_to", i), 32'(timeout), 32'd0);
        end
        send_byte(nn[15:8]);
        for (int k = 0; k < v.n; k++) begin
            send_byte(v.w[k][15:8]);
            send_byte(v.w[k][7:0]);
        end
        wait_done(v.halt_at, lbase);
        chk($sformatf("v%0d_result", i), 32'(result), 32'(v.ramv));
        chk($sformatf("v%0d_valid", i), 32'(result_valid), 32'd1);
        chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(v.exp_to));
        chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(v.exp_ovf));
        chk($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'd1);
        chk($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'd1);
        chk($sformatf("v%0d_run_cycles", i), 32'(low_cnt - lbase), 32'(v.exp_low));
        exp_cnt = (v.n < DEPTH) ? v.n : DEPTH;
`ifdef BOOT_RUNNER_PAD_EN
        if (v.n < DEPTH) exp_cnt = DEPTH;
`endif
        nw = wr_log.size() - wbase;
        chk($sformatf("v%0d_wr_count", i), 32'(nw), 32'(exp_cnt));
        for (int k = 0; k < exp_cnt && k < nw; k++) begin
            chk($sformatf("v%0d_wr%0d_addr", i, k), 32'(wr_log[wbase+k].a), 32'(k));
            chk($sformatf("v%0d_wr%0d_data", i, k), 32'(wr_log[wbase+k].d),
                (k < v.n) ? 32'(v.w[k]) : 32'd0);
        end
    endtask

    vec_t vecs [6];

    initial begin
        int wbase, lbase;
        vecs[0] = '{3, {16'h1234, 16'h5678, 16'h9ABC, 16'h0, 16'h0, 16'h0}, 10, 16'h002A, 11, 1'b0, 1'b0};
        vecs[1] = '{3, {16'h1234, 16'h5678, 16'h9ABC, 16'h0, 16'h0, 16'h0}, -1, 16'hBEEF, 20, 1'b1, 1'b0};
        vecs[2] = '{6, {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666}, 3, 16'h0777, 4, 1'b0, 1'b1};
        vecs[3] = '{1, {16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 19, 16'h0A0A, 20, 1'b0, 1'b0};
        vecs[4] = '{4, {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0, 16'h0}, 5, 16'h1357, 6, 1'b0, 1'b0};
        vecs[5] = '{0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 16'h2468, 3, 1'b0, 1'b0};

        for (int a = 0; a < DEPTH; a++) ram[a] = 16'hDEAD;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        cpu_halt = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_rom_we", 32'(rom_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({result_valid, timeout, overflow}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_to_hdr_rx_ready", 32'(rx_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in the middle of LOAD: one full word written, half of the next one sent
        send_byte(8'h02);
        send_byte(8'h00);
        wbase = wr_log.size();
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h55);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_pre_writes", 32'(wr_log.size() - wbase), 32'd1);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_flags", 32'({result_valid, timeout, overflow}), 32'd0);

        ram[RESULT_ADDR] = 16'h5A5A;
        wbase = wr_log.size();
        lbase = low_cnt;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hC3);
        send_byte(8'hC3);
        wait_done(0, lbase);
        chk("newimg_first_addr", (wr_log.size() > wbase) ? 32'(wr_log[wbase].a) : 32'hFFFF_FFFF, 32'd0);
        chk("newimg_first_data", (wr_log.size() > wbase) ? 32'(wr_log[wbase].d) : 32'hFFFF_FFFF, 32'h0000_C3C3);
        chk("newimg_run_cycles", 32'(low_cnt - lbase), 32'd1);
        chk("newimg_result", 32'(result), 32'h0000_5A5A);
        chk("newimg_valid", 32'(result_valid), 32'd1);

        chk("no_write_during_run", 32'(wr_in_run), 32'd0);
        chk("no_rx_ready_during_run", 32'(rdy_in_run), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
